rgb_pwm_driver: RTL and testbench



---
 rtl/rgb_pwm_driver.sv | 98 +++++++++
 tb/tb_rgb_pwm_driver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM LED driver with a one-deep duty buffer that is applied only at PWM
// period boundaries, so the pins never glitch mid-period.
module rgb_pwm_driver #(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned PRESCALE   = 47,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty_r,
  input  logic [PWM_BITS-1:0] duty_g,
  input  logic [PWM_BITS-1:0] duty_b,
  input  logic                duty_valid,
  output logic                duty_ready,
  output logic                frame_start,
  output logic                RGB_R,
  output logic                RGB_G,
  output logic                RGB_B
);

  localparam int unsigned PsW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE);
  localparam logic [PWM_BITS-1:0] CntMax = '1;
  // The counter stops one short of all-ones so a full-scale duty stays lit across the wrap.
  localparam logic [PWM_BITS-1:0] CntLast = CntMax - PWM_BITS'(1);

  // Index 2 = red, 1 = green, 0 = blue.
  logic [2:0][PWM_BITS-1:0] act_q, act_d;
  logic [2:0][PWM_BITS-1:0] pend_q, pend_d;
  logic                     pend_full_q, pend_full_d;
  logic [PsW-1:0]           ps_q, ps_d;
  logic [PWM_BITS-1:0]      cnt_q, cnt_d;
  logic                     frame_q, frame_d;
  logic [2:0]               pin_q, pin_d;
  logic [2:0]               lit;
  logic                     tick;
  logic                     boundary;
  logic                     accept;

  assign tick     = (ps_q == PsLast);
  assign boundary = tick && (cnt_q == CntLast);
  assign accept   = duty_valid && !pend_full_q;

  always_comb begin
    ps_d        = tick ? '0 : ps_q + PsW'(1);
    cnt_d       = cnt_q;
    act_d       = act_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    frame_d     = boundary;
    lit         = '0;

    if (tick) begin
      cnt_d = boundary ? '0 : cnt_q + PWM_BITS'(1);
    end

    // accept needs an empty buffer and apply needs a full one, so they never collide.
    if (accept) begin
      pend_d      = {duty_r, duty_g, duty_b};
      pend_full_d = 1'b1;
    end else if (boundary && pend_full_q) begin
      act_d       = pend_q;
      pend_full_d = 1'b0;
    end

    for (int i = 0; i < 3; i++) begin
      lit[i] = (cnt_q < act_q[i]);
    end
    pin_d = lit ^ {3{ACTIVE_LOW}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q        <= '0;
      cnt_q       <= '0;
      act_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      frame_q     <= 1'b0;
      pin_q       <= {3{ACTIVE_LOW}};
    end else begin
      ps_q        <= ps_d;
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      frame_q     <= frame_d;
      pin_q       <= pin_d;
    end
  end

  assign duty_ready  = !pend_full_q;
  assign frame_start = frame_q;
  assign RGB_R       = pin_q[2];
  assign RGB_G       = pin_q[1];
  assign RGB_B       = pin_q[0];

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: expected pin/frame waveforms are queued per cycle when
// duties are written and compared on the falling edge as the DUTs run.
module tb_rgb_pwm_driver;

  localparam int unsigned Bits   = 4;
  localparam int          Tick   = 2;            // PRESCALE + 1
  localparam int          Period = 30;           // Tick * (2^Bits - 1)

  typedef struct {
    int         at;
    logic [3:0] exp;
    string      tag;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [Bits-1:0] r1, g1, b1, r2, g2, b2;
  logic            v1, v2;
  logic            ready1, ready2, fs1, fs2;
  logic            pr1, pg1, pb1, pr2, pg2, pb2;

  int   cyc;
  int   checks = 0;
  int   errors = 0;
  ent_t q1[$];
  ent_t q2[$];

  rgb_pwm_driver #(.PWM_BITS(Bits), .PRESCALE(1), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .duty_r(r1), .duty_g(g1), .duty_b(b1), .duty_valid(v1),
    .duty_ready(ready1), .frame_start(fs1), .RGB_R(pr1), .RGB_G(pg1), .RGB_B(pb1)
  );

  rgb_pwm_driver #(.PWM_BITS(Bits), .PRESCALE(1), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .duty_r(r2), .duty_g(g2), .duty_b(b2), .duty_valid(v2),
    .duty_ready(ready2), .frame_start(fs2), .RGB_R(pr2), .RGB_G(pg2), .RGB_B(pb2)
  );

  always #5 clk = ~clk;

  // Clock edges since the last reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    while (q1.size() > 0 && q1[0].at <= cyc) begin
      ent_t e;
      e = q1.pop_front();
      checks++;
      assert (({fs1, pr1, pg1, pb1} === e.exp) && (e.at == cyc)) else begin
        errors++;
        $error("FAIL %s cyc=%0d at=%0d got=%b exp=%b", e.tag, cyc, e.at,
               {fs1, pr1, pg1, pb1}, e.exp);
      end
    end
    while (q2.size() > 0 && q2[0].at <= cyc) begin
      ent_t e;
      e = q2.pop_front();
      checks++;
      assert (({3'b000, pr2} === e.exp) && (e.at == cyc)) else begin
        errors++;
        $error("FAIL %s cyc=%0d at=%0d got=%b exp=%b", e.tag, cyc, e.at, {3'b000, pr2}, e.exp);
      end
    end
  end

  // Pin after edge k reflects the counter after edge k-1: tick index (j-1)/Tick in period p.
  task automatic expect_lo(input int p, input int dr, input int dg, input int db,
                           input int nj, input string tag);
    for (int j = 1; j <= nj; j++) begin
      ent_t e;
      int   t;
      t     = (j - 1) / Tick;
      e.at  = p * Period + j;
      e.exp = {j == Period, !(t < dr), !(t < dg), !(t < db)};
      e.tag = tag;
      q1.push_back(e);
    end
  endtask

  task automatic expect_hi(input int p, input int dr, input string tag);
    for (int j = 1; j <= Period; j++) begin
      ent_t e;
      e.at  = p * Period + j;
      e.exp = {3'b000, ((j - 1) / Tick) < dr};
      e.tag = tag;
      q2.push_back(e);
    end
  endtask

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc != n && guard < 2000);
    checks++;
    assert (cyc == n) else begin
      errors++;
      $error("FAIL wait_timeout got=%0d exp=%0d", cyc, n);
      $fatal(1, "cycle target not reached");
    end
  endtask

  task automatic drive_lo(input int r, input int g, input int b);
    r1 = Bits'(r);
    g1 = Bits'(g);
    b1 = Bits'(b);
    v1 = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    {r1, g1, b1, r2, g2, b2} = '0;
    v1 = 1'b0;
    v2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_lo", {fs1, pr1, pg1, pb1}, 4'b0111);
    check("rst_ready", {2'b00, ready1, ready2}, 4'b0011);
    check("rst_hi", {fs2, pr2, pg2, pb2}, 4'b0000);
    rst = 1'b0;
    expect_lo(0, 0, 0, 0, Period, "p0_idle");
    expect_hi(0, 0, "hi_p0_idle");

    // First write at cycle 5; applied at the boundary at cycle 30.
    wait_cyc(4);
    drive_lo(15, 0, 8);
    r2 = Bits'(5);
    v2 = 1'b1;
    wait_cyc(5);
    check("w1_ready", {2'b00, ready1, ready2}, 4'b0000);
    v1 = 1'b0;
    v2 = 1'b0;
    expect_lo(1, 15, 0, 8, Period, "p1_r15_g0_b8");
    expect_hi(1, 5, "hi_p1_r5");
    wait_cyc(29);
    check("w1_ready_pre_bnd", {3'b000, ready1}, 4'b0000);
    wait_cyc(30);
    check("w1_ready_at_bnd", {3'b000, ready1}, 4'b0001);

    // Back-pressure: A accepted, B held until A is applied.
    wait_cyc(34);
    drive_lo(4, 12, 0);
    wait_cyc(35);
    check("bp_a_ready", {3'b000, ready1}, 4'b0000);
    drive_lo(10, 2, 15);
    expect_lo(2, 4, 12, 0, Period, "p2_a");
    expect_lo(3, 10, 2, 15, Period, "p3_b");
    wait_cyc(59);
    check("bp_stall", {3'b000, ready1}, 4'b0000);
    wait_cyc(60);
    check("bp_ready_at_bnd", {3'b000, ready1}, 4'b0001);
    wait_cyc(61);
    check("bp_b_taken", {3'b000, ready1}, 4'b0000);
    v1 = 1'b0;

    // Triple offered in the boundary cycle itself.
    wait_cyc(119);
    check("bc_ready", {3'b000, ready1}, 4'b0001);
    drive_lo(1, 15, 6);
    wait_cyc(120);
    check("bc_taken", {3'b000, ready1}, 4'b0000);
    v1 = 1'b0;
    expect_lo(4, 10, 2, 15, Period, "p4_b_kept");
    expect_lo(5, 1, 15, 6, Period, "p5_c");
    wait_cyc(149);
    check("bc_ready_pre", {3'b000, ready1}, 4'b0000);
    wait_cyc(150);
    check("bc_ready_post", {3'b000, ready1}, 4'b0001);

    // Full duty active plus a pending triple, then reset mid-period.
    drive_lo(15, 15, 15);
    wait_cyc(151);
    v1 = 1'b0;
    expect_lo(6, 15, 15, 15, 15, "p6_full");
    wait_cyc(185);
    drive_lo(3, 3, 3);
    wait_cyc(186);
    check("mr_pending", {3'b000, ready1}, 4'b0000);
    v1 = 1'b0;
    wait_cyc(195);
    rst = 1'b1;
    #1;
    check("mr_async_pins", {fs1, pr1, pg1, pb1}, 4'b0111);
    check("mr_async_ready", {3'b000, ready1}, 4'b0001);
    check("mr_async_hi", {3'b000, pr2}, 4'b0000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expect_lo(0, 0, 0, 0, Period, "mr_p0_unlit");
    expect_lo(1, 0, 0, 0, Period, "mr_p1_discarded");
    wait_cyc(1);
    check("mr_ready", {3'b000, ready1}, 4'b0001);
    wait_cyc(2 * Period + 1);

    checks++;
    assert ((q1.size() == 0) && (q2.size() == 0)) else begin
      errors++;
      $error("FAIL sb_drain got=%0d exp=0", q1.size() + q2.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
